// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings driven on muldiv_unit.op
//   - default datapath width and the divide-by-zero quotient value
//   - FSM state type shared by the top level and anything observing it
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [WIDTH_DEFAULT-1:0] DIVZERO_LO = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div   : 1 = restoring shift-subtract step, 0 = shift-add step
//   acc_hi   : upper accumulator (partial product / partial remainder)
//   acc_lo   : lower accumulator (multiplier bits / dividend bits -> quotient)
//   operand  : multiplicand (multiply) or divisor (divide), magnitudes only
//   next_hi  : accumulator upper half after this step
//   next_lo  : accumulator lower half after this step
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the {carry, hi, lo} triple right by one.
        sum     = {1'b0, acc_hi} + {1'b0, operand};
        // Divide: bring the next dividend bit into the partial remainder.
        // The remainder is always below the divisor, so the shifted value
        // needs one extra bit and the difference fits back in WIDTH bits.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        diff    = shifted[WIDTH-1:0] - operand;

        next_hi = acc_hi;
        next_lo = acc_lo;
        if (is_div) begin
            if (fits) begin
                next_hi = diff;
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            next_hi = {1'b0, acc_hi[WIDTH-1:1]};
            next_lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding architectural HI/LO.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start, op  : request and operation code (muldiv_pkg OP_*)
//   a, b       : operands, captured on the accepting edge only
//   busy       : high while a MULT/MULTU/DIV/DIVU is iterating
//   done       : one-cycle pulse after HI/LO receive an arithmetic result
//   hi, lo     : architectural HI/LO registers
//
// Handshake: a request is start=1 at a rising edge while busy=0. Arithmetic
// ops raise busy for WIDTH cycles and then pulse done with hi/lo updated;
// MTHI/MTLO update the register at the accepting edge with no busy/done.
// start while busy=1 is dropped entirely. The done cycle has busy=0, so a
// request presented there is accepted.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;
    logic             is_div;
    logic             neg_main;   // negate product, or negate quotient
    logic             neg_rem;    // negate remainder (follows dividend sign)

    logic             op_signed;
    logic             op_div;
    logic             op_arith;
    logic             div_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy = (state == RUN);

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        op_arith  = (op[2] == 1'b0);
        div_zero  = op_div && (b == '0);
        // A signed divide by zero runs on the raw dividend so the remainder
        // comes out as a exactly as presented, with no sign fix-up.
        a_neg     = op_signed && a[WIDTH-1] && !div_zero;
        b_neg     = op_signed && b[WIDTH-1];
        abs_a     = a_neg ? -a : a;
        abs_b     = b_neg ? -b : b;

        prod      = {step_hi, step_lo};
        prod_fix  = neg_main ? -prod : prod;
        quot_fix  = neg_main ? -step_lo : step_lo;
        rem_fix   = neg_rem ? -step_hi : step_hi;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_arith) begin
                            state    <= RUN;
                            cnt      <= '0;
                            acc_hi   <= '0;
                            // Multiply keeps the multiplicand in operand and
                            // shifts the multiplier out of acc_lo; divide keeps
                            // the divisor in operand and shifts the dividend.
                            acc_lo   <= op_div ? abs_a : abs_b;
                            operand  <= op_div ? abs_b : abs_a;
                            is_div   <= op_div;
                            neg_main <= a_neg ^ b_neg;
                            neg_rem  <= op_div && a_neg;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    int busy_cycles;
    int done_pulses;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: presents a request for the next rising edge, then
    // returns at the following negedge with operands scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Returns at the negedge where done is seen (or after the budget).
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic run_arith(input string tag, input logic [2:0] o, input logic [31:0] av,
                             input logic [31:0] bv, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        issue(o, av, bv);
        wait_done(tag);
        check({tag, "_busy_cycles"}, busy_cycles, 32);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        busy_cycles = 0;
        done_pulses = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // MULTU full-scale, done lasts one cycle
        run_arith("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        check("multu_done_pulse_len", done, 1'b0);
        check("multu_busy_after", busy, 1'b0);

        run_arith("mult_neg",  OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_arith("div_neg",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_arith("divu_7_2",  OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_arith("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_arith("divu_zero", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
        run_arith("div_zero_neg", OP_DIV, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFFF);
        @(negedge clk);

        // MTHI then MTLO on consecutive cycles
        issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_lo_kept", lo, 32'hFFFFFFFF);
        check("mthi_busy", busy, 1'b0);
        issue(OP_MTLO, 32'hCAFEF00D, 32'h0);
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi_kept", hi, 32'hDEADBEEF);
        check("mtlo_done", done, 1'b0);

        // Requests during a MULT are ignored; hi/lo hold while busy
        issue(OP_MULT, 32'd100, 32'hFFFFFFFE);
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_MTLO; a = 32'h55;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("busy_hold_lo", lo, 32'hCAFEF00D);
        check("busy_hold_hi", hi, 32'hDEADBEEF);
        check("busy_still", busy, 1'b1);
        wait_done("mult_ignored");
        check("mult_ignored_hi", hi, 32'hFFFFFFFF);
        check("mult_ignored_lo", lo, 32'hFFFFFF38);

        // Back-to-back request on the done cycle
        run_arith("divu_b2b", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        @(negedge clk);

        // Reset aborts an in-flight DIV
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        repeat (40) begin
            if (done === 1'b1) done_pulses++;
            @(negedge clk);
        end
        check("abort_no_done", done_pulses, 0);
        run_arith("multu_6_7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 32-bit multiply/divide unit for the integer datapath. It holds architectural HI/LO registers, which feed the 4-input 32-bit result-select multiplexer directly downstream (HI and LO occupy two of its data inputs).
- One result bit is produced per clock.
- Control sees a start/busy/done handshake.
- MTHI/MTLO writes complete in a single cycle.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count = WIDTH; counter width = clog2(WIDTH)+1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled at rising edge of clk
op  input  3  operation code (encodings in Decomposition)
a  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO data)
b  input  WIDTH  operand B (multiplier / divisor)
busy  output  1  operation in progress; new requests ignored
done  output  1  one-cycle pulse: HI/LO updated by MULT/MULTU/DIV/DIVU
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (sampled high at an edge):
  - busy=0, done=0, hi=0, lo=0; iteration counter and working registers cleared.
  - Aborts any in-flight operation with no result written.
  - Reset has priority over start.
- Idle (busy=0), start=1 at edge E0:
  - MULT/MULTU/DIV/DIVU:
    - Latch operands at E0. Signed ops latch absolute values plus result-sign flags.
    - busy=1 from E0 until E32.
    - One shift-add (multiply) or restoring shift-subtract (divide) step per edge, E1..E32.
    - At E32: hi/lo written with sign-corrected result; busy->0; done->1 for exactly one cycle.
    - Latency: result visible and done=1 in the cycle after edge E32, i.e. 33 edges after the request.
  - MTHI: hi<=a at E0. MTLO: lo<=a at E0. No busy, no done; the other register is unchanged.
  - Reserved ops 6/7: no effect.
- start=1 while busy=1: ignored, including MTHI/MTLO. Latched operands are unaffected.
- A new request in the same cycle that done=1 is accepted (busy already 0).
- hi/lo hold their values during busy. They change only at the completion edge, on MTHI/MTLO, or on reset.
- Signed multiply: 64-bit product is negated when sign(a) xor sign(b).
- Signed divide:
  - Quotient is negated when sign(a) xor sign(b).
  - Remainder takes sign(a), so that a = q*b + r.
  - -2^31 / -1 gives lo=32'h80000000, hi=0.
- Divide by zero (DIV or DIVU, b=0):
  - Runs the full 32 iterations; no sign correction is applied.
  - Result: lo=32'hFFFFFFFF, hi=a as presented.
- Operands a and b need not be held stable after E0.

Decomposition:
- Shared package `muldiv_pkg`:
  - op encodings: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5.
  - constants WIDTH_DEFAULT=32 and DIVZERO_LO=all-ones.
- FSM states IDLE, RUN (enum in package); done is a registered pulse from the RUN->IDLE transition.
- One natural sub-module: `muldiv_step`. It is a combinational single-iteration datapath (add/shift or trial-subtract/shift) selected by a mul/div flag, and the top module holds the counter, FSM and HI/LO.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 33 edges done=1, hi=32'hFFFFFFFE, lo=32'h00000001; busy high exactly 32 cycles.
- MULT a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0. DIVU a=32'h1234, b=0 -> lo=32'hFFFFFFFF, hi=32'h1234, normal latency.
- MTHI a=32'hDEADBEEF then MTLO a=32'hCAFEF00D on consecutive cycles -> hi/lo updated the cycle after each request; done stays 0.
- During a MULT, pulse start with MTLO and with DIVU (new operands) -> both ignored; original MULT result is correct. Back-to-back start on the done cycle -> second op accepted.
- Assert reset at iteration 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows; a subsequent MULTU 6*7 gives lo=42, hi=0.
